// File: rtl/flash_audio_pkg.sv
// Shared definitions for the flash audio playback path.
//   state_t    : sequencer / reader state encoding
//   SAMPLE_W   : audio sample width (two samples per 32-bit flash word)
//   BYTEEN_ALL : full-word Avalon byte enable
//   DIR_FW/BW  : playback direction encodings
//   pick_half  : selects the upper or lower sample of a flash word
package flash_audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    OUT1,
    WAIT2,
    OUT2
  } state_t;

  localparam int         SAMPLE_W   = 16;
  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  localparam logic DIR_FW = 1'b0;
  localparam logic DIR_BW = 1'b1;

  function automatic logic [SAMPLE_W-1:0] pick_half(input logic [31:0] word,
                                                    input logic        upper);
    return upper ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/flash_avalon_reader.sv
// Single-word Avalon-MM read master.
//   start/addr          : begin one read at addr (accepted only when idle)
//   done                : one-cycle strobe, readdata is captured into data on this edge
//   data                : last word returned, held until the next read completes
//   read/address/byteenable/waitrequest/readdata/readdatavalid : Avalon-MM read port
// A read request is held until waitrequest drops; it is never withdrawn early.
module flash_avalon_reader
  import flash_audio_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              read,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: every signal driven here gets a default before the case; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (!waitrequest) begin
          // Data may come back in the very cycle the request is accepted.
          if (readdatavalid) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (readdatavalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers are updated with <= so every flop samples pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start && state_q == IDLE) addr_q <= addr;
      if (done)                     data_q <= readdata;
    end
  end

  // A late readdatavalid after reset lands in IDLE and is ignored.
  assign read       = (state_q == REQ);
  assign address    = addr_q;
  assign byteenable = BYTEEN_ALL;
  assign data       = data_q;

endmodule

// File: rtl/flash_sample_sequencer.sv
// Flash-to-audio sample sequencer.
// Fetches one 32-bit word per pair of sample ticks and plays its two 16-bit
// halves in the direction latched at fetch time.
//   sample_tick/play_en/dir_bw/word_addr : playback control from the address controller
//   addr_step                            : pulse when both halves of a word are played
//   flash_mem_*                          : Avalon-MM read port to flash
//   audio_data/audio_valid               : sample register and its update strobe
//   sample_miss                          : sticky, set by a tick arriving while busy
module flash_sample_sequencer
  import flash_audio_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                play_en,
  input  logic                dir_bw,
  input  logic [ADDR_W-1:0]   word_addr,
  output logic                addr_step,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic [3:0]          flash_mem_byteenable,
  input  logic                flash_mem_waitrequest,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                audio_valid,
  output logic                sample_miss
);

  state_t            state_q, state_d;
  logic              start;
  logic              rd_done;
  logic [DATA_W-1:0] rd_word;
  logic              dir_q;
  logic              miss_tick;

  flash_avalon_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_reader (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .addr         (word_addr),
    .done         (rd_done),
    .data         (rd_word),
    .read         (flash_mem_read),
    .address      (flash_mem_address),
    .byteenable   (flash_mem_byteenable),
    .waitrequest  (flash_mem_waitrequest),
    .readdata     (flash_mem_readdata),
    .readdatavalid(flash_mem_readdatavalid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The whole Avalon handshake (REQ and WAIT_DATA) is tracked here as REQ;
  // the reader reports completion through rd_done.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    miss_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick && play_en) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ, WAIT_DATA: begin
        miss_tick = sample_tick;
        if (rd_done) state_d = OUT1;
      end
      OUT1: begin
        miss_tick = sample_tick;
        state_d   = WAIT2;
      end
      // Paused mid-word: the second half stays in the word register.
      WAIT2: if (sample_tick && play_en) state_d = OUT2;
      OUT2: begin
        miss_tick = sample_tick;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      audio_data  <= '0;
      audio_valid <= 1'b0;
      addr_step   <= 1'b0;
      sample_miss <= 1'b0;
      dir_q       <= DIR_FW;
    end else begin
      audio_valid <= 1'b0;
      addr_step   <= 1'b0;
      if (start)     dir_q       <= dir_bw;
      if (miss_tick) sample_miss <= 1'b1;
      if (state_q == OUT1) begin
        audio_data  <= pick_half(rd_word, dir_q == DIR_BW);
        audio_valid <= 1'b1;
      end
      if (state_q == OUT2) begin
        audio_data  <= pick_half(rd_word, dir_q == DIR_FW);
        audio_valid <= 1'b1;
        addr_step   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
module tb_flash_sample_sequencer;

  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_tick = 1'b0;
  logic              play_en = 1'b0;
  logic              dir_bw = 1'b0;
  logic [ADDR_W-1:0] word_addr = '0;
  logic              addr_step;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;
  logic [15:0]       audio_data;
  logic              audio_valid;
  logic              sample_miss;

  flash_sample_sequencer #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .sample_tick            (sample_tick),
    .play_en                (play_en),
    .dir_bw                 (dir_bw),
    .word_addr              (word_addr),
    .addr_step              (addr_step),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_byteenable   (flash_mem_byteenable),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdata     (flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .audio_data             (audio_data),
    .audio_valid            (audio_valid),
    .sample_miss            (sample_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        step;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [31:0]       mem[int];

  int n_cmp = 0;
  int n_bad = 0;
  int reads_issued = 0;
  int reads_seen = 0;
  int valid_seen = 0;
  int wait_cfg = 0;
  int delay_cfg = 1;
  logic miss_exp = 1'b0;
  logic [31:0] cur_word;
  logic        cur_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    if (!mem.exists(int'(a))) mem[int'(a)] = $urandom;
    return mem[int'(a)];
  endfunction

  // Reference: a word played forward yields low half then high half,
  // backward yields high half then low half.
  function automatic logic [15:0] half_of(input logic [31:0] w, input logic upper);
    logic [31:0] s;
    s = upper ? (w >> 16) : w;
    return s[15:0];
  endfunction

  // Flash slave: waitrequest for wait_cfg cycles, data delay_cfg cycles after acceptance.
  initial begin : slave
    logic [ADDR_W-1:0] ea;
    logic [31:0]       w;
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      if (flash_mem_read) begin
        reads_seen++;
        if (addr_q.size() == 0) begin
          check("unexpected flash read (queue size)", addr_q.size(), 1);
          ea = flash_mem_address;
        end else begin
          ea = addr_q.pop_front();
        end
        check("flash_mem_address", flash_mem_address, ea);
        for (int i = 0; i < wait_cfg; i++) begin
          flash_mem_waitrequest = 1'b1;
          @(posedge clk); #1;
          check("read held under wait", flash_mem_read, 1);
          check("address held under wait", flash_mem_address, ea);
        end
        flash_mem_waitrequest = 1'b0;
        w = word_at(ea);
        if (delay_cfg == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata      = w;
          @(posedge clk); #1;
        end else begin
          @(posedge clk); #1;
          check("read dropped after accept", flash_mem_read, 0);
          repeat (delay_cfg - 1) @(posedge clk);
          #1;
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata      = w;
          @(posedge clk); #1;
        end
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = $urandom;
      end
    end
  end

  // Monitor: every audio output is popped against the scoreboard.
  initial begin : monitor
    exp_t e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (audio_valid || addr_step) begin
        if (audio_valid) valid_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected audio output (queue size)", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("audio_valid", audio_valid, 1);
          check("audio_data", audio_data, e.data);
          check("addr_step", addr_step, e.step);
        end
      end
      if (audio_valid && prev_valid) check("audio_valid back-to-back", prev_valid, 0);
      prev_valid = audio_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    bit got;
    got = 0;
    n   = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      n++;
      if (audio_valid) got = 1;
    end
    if (!got) check({name, " audio_valid timeout"}, audio_valid, 1);
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  task automatic first_half(input logic [ADDR_W-1:0] a, input logic d, input int w,
                            input int dly, input bit miss, input bit pause);
    exp_t e;
    int   n;
    word_addr = a;
    dir_bw    = d;
    wait_cfg  = w;
    delay_cfg = dly;
    cur_word  = word_at(a);
    cur_dir   = d;
    addr_q.push_back(a);
    reads_issued++;
    e.data = half_of(cur_word, d);
    e.step = 1'b0;
    exp_q.push_back(e);
    tick();
    // Both must be ignored until the next fetch.
    word_addr = ADDR_W'($urandom);
    dir_bw    = 1'($urandom);
    if (pause) play_en = 1'b0;
    if (miss) begin
      tick();
      miss_exp = 1'b1;
    end
    wait_valid("first half", n);
    if (!miss) check("first-sample latency", n, 3 + w + dly);
    play_en = 1'b1;
    check("sample_miss", sample_miss, miss_exp);
  endtask

  task automatic second_half();
    exp_t e;
    int   n;
    e.data = half_of(cur_word, !cur_dir);
    e.step = 1'b1;
    exp_q.push_back(e);
    tick();
    wait_valid("second half", n);
  endtask

  initial begin : driver
    int v0;
    repeat (3) @(posedge clk);
    #1;
    check("reset audio_data", audio_data, 0);
    check("reset audio_valid", audio_valid, 0);
    check("reset addr_step", addr_step, 0);
    check("reset flash_mem_read", flash_mem_read, 0);
    check("reset flash_mem_address", flash_mem_address, 0);
    check("reset sample_miss", sample_miss, 0);
    check("byteenable", flash_mem_byteenable, 4'hF);
    reset   = 1'b0;
    play_en = 1'b1;
    mem[32'h10] = 32'hBEEF_1234;

    // Forward then backward on the same word, zero wait.
    first_half(23'h00010, 1'b0, 0, 1, 0, 0); gap(); second_half(); gap();
    first_half(23'h00010, 1'b1, 0, 1, 0, 0); gap(); second_half(); gap();

    // Long waitrequest.
    first_half(23'h00123, 1'b0, 5, 1, 0, 0); gap(); second_half(); gap();

    // Pause in WAIT2 across four ticks.
    first_half(23'h02000, 1'b1, 1, 2, 0, 0);
    play_en = 1'b0;
    v0 = valid_seen;
    repeat (4) begin
      tick();
      repeat (2) @(posedge clk);
    end
    check("no output while paused", valid_seen, v0);
    check("no miss while paused", sample_miss, miss_exp);
    play_en = 1'b1;
    second_half(); gap();

    // Randomised words, waits, delays and pauses during fetch.
    for (int k = 0; k < 20; k++) begin
      first_half(ADDR_W'($urandom), 1'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), 0, 1'($urandom));
      gap();
      second_half();
      gap();
    end

    // Overrun during a slow fetch.
    first_half(23'h7FFFFF, 1'b0, 0, 10, 1, 0); gap(); second_half(); gap();
    check("sample_miss sticky", sample_miss, 1);

    // Reset in WAIT_DATA; data arrives the cycle after reset and must be ignored.
    word_addr = 23'h00444;
    wait_cfg  = 0;
    delay_cfg = 2;
    addr_q.push_back(23'h00444);
    reads_issued++;
    tick();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    miss_exp = 1'b0;
    check("post-reset audio_data", audio_data, 0);
    check("post-reset audio_valid", audio_valid, 0);
    check("post-reset addr_step", addr_step, 0);
    check("post-reset flash_mem_read", flash_mem_read, 0);
    check("post-reset flash_mem_address", flash_mem_address, 0);
    check("post-reset sample_miss", sample_miss, 0);
    v0 = valid_seen;
    repeat (8) @(posedge clk);
    check("no output after reset", valid_seen, v0);
    check("post-reset still idle (no read)", flash_mem_read, 0);

    check("accepted read count", reads_seen, reads_issued);
    check("audio scoreboard drained", exp_q.size(), 0);
    check("address scoreboard drained", addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
